vga_sync_gen: RTL and testbench

//  Produces the VGA raster timing that the pixel/game renderers consume:

---
 rtl/vga_sync_gen.sv | 105 ++++++++++
 tb/tb_vga_sync_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate enable, x/y counters and registered
// video_on/hsync/vsync/frame_start that always describe the current (x,y).
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = H_DISPLAY + H_FRONT + H_SYNC - 1;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = V_DISPLAY + V_FRONT + V_SYNC - 1;
  localparam int          DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             p_tick_q, p_tick_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;

  always_comb begin
    div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;

    if (p_tick_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Registered p_tick keeps it low during reset even when CLK_DIV is 1.
    p_tick_d   = (div_cnt_d == DIV_LAST);
    // Decode from the next counter values so the flags land with x/y.
    video_on_d = (32'(x_d) < H_DISPLAY) && (32'(y_d) < V_DISPLAY);
    hsync_d    = ((32'(x_d) >= HS_START) && (32'(x_d) <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = ((32'(y_d) >= VS_START) && (32'(y_d) <= VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q     <= '0;
      p_tick_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      video_on_q    <= 1'b1;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      p_tick_q      <= p_tick_d;
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign p_tick      = p_tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 timing plus two shrunken builds
// (CLK_DIV=4 and CLK_DIV=1/active-high syncs) so full frames fit the run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       pt_def, von_def, hs_def, vs_def, fs_def;
  logic [9:0] x_def, y_def;
  logic       pt_sml, von_sml, hs_sml, vs_sml, fs_sml;
  logic [9:0] x_sml, y_sml;
  logic       pt_one, von_one, hs_one, vs_one, fs_one;
  logic [9:0] x_one, y_one;

  vga_sync_gen u_def (
    .clk(clk), .reset(reset), .p_tick(pt_def), .x(x_def), .y(y_def),
    .video_on(von_def), .hsync(hs_def), .vsync(vs_def), .frame_start(fs_def)
  );

  vga_sync_gen #(
    .CLK_DIV(4), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
  ) u_sml (
    .clk(clk), .reset(reset), .p_tick(pt_sml), .x(x_sml), .y(y_sml),
    .video_on(von_sml), .hsync(hs_sml), .vsync(vs_sml), .frame_start(fs_sml)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .SYNC_POL(1'b1)
  ) u_one (
    .clk(clk), .reset(reset), .p_tick(pt_one), .x(x_one), .y(y_one),
    .video_on(von_one), .hsync(hs_one), .vsync(vs_one), .frame_start(fs_one)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_q;
  logic mon_en = 1'b0;

  // Clocks seen since the last reset release; the model is a function of it.
  always @(posedge clk or posedge reset)
    if (reset) n_q <= 0;
    else       n_q <= n_q + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t n=%0d)", name, act, exp, $time, n_q);
    end
  endtask

  // Pixels completed after n clocks. p_tick is 0 in reset, so with CLK_DIV=1
  // the first advance happens one clock after release.
  function automatic int pix_at(int n, int d);
    if (n == 0) return 0;
    return (d == 1) ? n - 1 : n / d;
  endfunction

  // Packed {p_tick, x, y, video_on, hsync, vsync, frame_start}.
  function automatic logic [24:0] model(int n, int d, int hd, int hf, int hs, int hb,
                                        int vd, int vf, int vs, int vb, logic pol);
    int ht, vt, pix, pprev, xx, yy;
    logic pt, von, hsy, vsy, fs;
    ht    = hd + hf + hs + hb;
    vt    = vd + vf + vs + vb;
    pix   = pix_at(n, d);
    pprev = (n > 0) ? pix_at(n - 1, d) : 0;
    xx    = pix % ht;
    yy    = (pix / ht) % vt;
    pt    = (n > 0) && (n % d == d - 1);
    von   = (xx < hd) && (yy < vd);
    hsy   = (xx >= hd + hf && xx < hd + hf + hs) ? pol : ~pol;
    vsy   = (yy >= vd + vf && yy < vd + vf + vs) ? pol : ~pol;
    fs    = (pix != pprev) && (pix % (ht * vt) == 0);
    return {pt, 10'(xx), 10'(yy), von, hsy, vsy, fs};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_def", 32'({pt_def, x_def, y_def, von_def, hs_def, vs_def, fs_def}),
            32'(model(n_q, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)));
      check("mon_sml", 32'({pt_sml, x_sml, y_sml, von_sml, hs_sml, vs_sml, fs_sml}),
            32'(model(n_q, 4, 8, 2, 3, 2, 6, 2, 2, 3, 1'b0)));
      check("mon_one", 32'({pt_one, x_one, y_one, von_one, hs_one, vs_one, fs_one}),
            32'(model(n_q, 1, 5, 1, 2, 1, 3, 1, 1, 2, 1'b1)));
    end
  end

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       pt;
    logic       von;
    logic       hs;
  } vec_t;

  vec_t vecs[12];

  task automatic frame_periods(input string name, input int period, input bit use_sml);
    int seen, guard, t_prev;
    seen = 0; guard = 0; t_prev = 0;
    while (seen < 3 && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (use_sml ? fs_sml : fs_one) begin
        check({name, "_xy"}, use_sml ? 32'({x_sml, y_sml}) : 32'({x_one, y_one}), 32'd0);
        if (seen > 0) check({name, "_period"}, 32'(n_q - t_prev), 32'(period));
        t_prev = n_q;
        seen++;
        @(negedge clk);
        guard++;
        check({name, "_width"}, 32'(use_sml ? fs_sml : fs_one), 32'd0);
      end
    end
    check({name, "_pulses"}, 32'(seen), 32'd3);
  endtask

  initial begin
    int guard;
    vecs[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{2,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{3,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{4,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{2559, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{2560, 10'd640, 10'd0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{2623, 10'd655, 10'd0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{2624, 10'd656, 10'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3007, 10'd751, 10'd0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3008, 10'd752, 10'd0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{3199, 10'd799, 10'd0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{3200, 10'd0,   10'd1, 1'b0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_def", 32'({pt_def, x_def, y_def, von_def, hs_def, vs_def, fs_def}),
          32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}));
    check("rst_one_pt_sync", 32'({pt_one, hs_one, vs_one}), 32'd0);
    mon_en = 1'b1;
    #1 reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      guard = 0;
      while (n_q < vecs[i].n && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("vec%0d_n", i), 32'(n_q), 32'(vecs[i].n));
      check($sformatf("vec%0d_xy", i), 32'({x_def, y_def}), 32'({vecs[i].x, vecs[i].y}));
      check($sformatf("vec%0d_flags", i), 32'({pt_def, von_def, hs_def}),
            32'({vecs[i].pt, vecs[i].von, vecs[i].hs}));
    end

    frame_periods("fs_sml", 780, 1'b1);
    frame_periods("fs_one", 63, 1'b0);

    // Mid-frame async reset: outputs return to the origin before any edge.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_def", 32'({pt_def, x_def, y_def, von_def, hs_def, vs_def, fs_def}),
          32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}));
    check("midrst_sml", 32'({pt_sml, x_sml, y_sml, fs_sml}), 32'd0);
    check("midrst_one", 32'({pt_one, x_one, y_one, hs_one, vs_one, fs_one}), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_pt%0d", k), 32'(pt_def), (k == 3) ? 32'd1 : 32'd0);
      check($sformatf("post_rst_x%0d", k), 32'(x_def), (k == 4) ? 32'd1 : 32'd0);
    end

    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(1, 2500)) @(negedge clk);
      @(posedge clk);
      #($urandom_range(1, 3)) reset = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      #($urandom_range(1, 3)) reset = 1'b0;
    end
    repeat (900) @(negedge clk);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
